tff_count_ctrl: RTL and testbench

TFF_COUNT_CTRL -- requirements
Module: tff_count_ctrl

---
 rtl/tff_ctrl_pkg.sv | 13 +
 rtl/tff_cell.sv | 21 ++
 rtl/tff_count_ctrl.sv | 131 +++++++++++++
 tb/tb_tff_count_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tff_ctrl_pkg.sv
// rtl/tff_ctrl_pkg.sv - shared state encoding and width default for the T-flop counter
package tff_ctrl_pkg;

    localparam int TFF_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_LOAD = 2'b10,
        ST_DONE = 2'b11
    } tff_state_e;

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T flip-flop with synchronous active-low clear
module tff_cell (
    input  logic t,
    input  logic clk,
    input  logic rst_n,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else begin
            r_q <= r_q ^ t;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/tff_count_ctrl.sv
// rtl/tff_count_ctrl.sv - up/down modulo counter built from T cells, driven by a start/stop/load FSM
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = TFF_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode_up,
    input  logic [WIDTH-1:0] mod_val,
    input  logic             one_shot,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    tff_state_e       r_state;
    tff_state_e       w_next;
    logic             r_mode;
    logic [WIDTH-1:0] r_mod;
    logic             r_os;
    logic             r_tc;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_t_up;
    logic [WIDTH-1:0] w_t_dn;
    logic             w_tc_next;
    logic             w_capture;

    // Carry/borrow prefixes: bit i toggles when every lower bit is 1 (up) or 0 (down).
    assign w_t_up[0] = 1'b1;
    assign w_t_dn[0] = 1'b1;
    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_prefix
            assign w_t_up[gi] = &q[gi-1:0];
            assign w_t_dn[gi] = &(~q[gi-1:0]);
        end
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            tff_cell u_cell (
                .t     (w_t[gi]),
                .clk   (clk),
                .rst_n (rst_n),
                .q     (q[gi])
            );
        end
    endgenerate

    always_comb begin
        w_next    = r_state;
        w_t       = '0;
        w_tc_next = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (load_en) begin
                    w_next = ST_LOAD;
                end else if (start) begin
                    w_next    = ST_RUN;
                    w_capture = 1'b1;
                end
            end
            ST_LOAD: begin
                w_t    = q ^ load_val;
                w_next = ST_IDLE;
            end
            ST_RUN: begin
                if (stop) begin
                    w_next = ST_IDLE;
                end else begin
                    if (r_mode) begin
                        if (q == r_mod) begin
                            w_t       = q;
                            w_tc_next = 1'b1;
                        end else begin
                            w_t = w_t_up;
                        end
                    end else begin
                        if (q == '0) begin
                            w_t       = q ^ r_mod;
                            w_tc_next = 1'b1;
                        end else begin
                            w_t = w_t_dn;
                        end
                    end
                    if (w_tc_next && r_os) begin
                        w_next = ST_DONE;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // busy/done come straight from flops loaded with the next-state decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mode  <= 1'b0;
            r_mod   <= '0;
            r_os    <= 1'b0;
            r_tc    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tc    <= w_tc_next;
            r_busy  <= (w_next == ST_RUN) || (w_next == ST_LOAD);
            r_done  <= (w_next == ST_DONE);
            if (w_capture) begin
                r_mode <= mode_up;
                r_mod  <= mod_val;
                r_os   <= one_shot;
            end
        end
    end

    assign busy = r_busy;
    assign tc   = r_tc;
    assign done = r_done;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb/tb_tff_count_ctrl.sv - directed scoreboard bench for tff_count_ctrl
module tb_tff_count_ctrl;

    typedef struct packed {
        logic [3:0] q;
        logic       busy;
        logic       tc;
        logic       done;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       load_en;
    logic [3:0] load_val;
    logic       mode_up;
    logic [3:0] mod_val;
    logic       one_shot;
    logic [3:0] q;
    logic       busy;
    logic       tc;
    logic       done;

    exp_t  sb_q[$];
    string tag_q[$];
    int    errors = 0;
    int    checks = 0;

    tff_count_ctrl #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .load_en  (load_en),
        .load_val (load_val),
        .mode_up  (mode_up),
        .mod_val  (mod_val),
        .one_shot (one_shot),
        .q        (q),
        .busy     (busy),
        .tc       (tc),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input logic [3:0] eq, input logic eb, input logic et,
                       input logic ed, input string tag);
        exp_t e;
        exp_t x;
        string t;
        e.q = eq; e.busy = eb; e.tc = et; e.done = ed;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (q === x.q) else begin
            errors++;
            $error("FAIL %s q got %0h exp %0h", t, q, x.q);
        end
        checks++;
        assert (busy === x.busy) else begin
            errors++;
            $error("FAIL %s busy got %0b exp %0b", t, busy, x.busy);
        end
        checks++;
        assert (tc === x.tc) else begin
            errors++;
            $error("FAIL %s tc got %0b exp %0b", t, tc, x.tc);
        end
        checks++;
        assert (done === x.done) else begin
            errors++;
            $error("FAIL %s done got %0b exp %0b", t, done, x.done);
        end
    endtask

    task automatic do_load(input logic [3:0] v, input logic [3:0] q_before);
        load_en = 1'b1; load_val = v;
        cyc(q_before, 1'b1, 1'b0, 1'b0, "load_cycle");
        load_en = 1'b0;
        cyc(v, 1'b0, 1'b0, 1'b0, "load_done");
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; stop = 1'b0; load_en = 1'b1;
        load_val = 4'h5; mode_up = 1'b1; mod_val = 4'h7; one_shot = 1'b0;
        cyc(4'h0, 1'b0, 1'b0, 1'b0, "reset1");
        cyc(4'h0, 1'b0, 1'b0, 1'b0, "reset2");
        rst_n = 1'b1; start = 1'b0; load_en = 1'b0;
        cyc(4'h0, 1'b0, 1'b0, 1'b0, "idle_hold");

        do_load(4'hA, 4'h0);

        // load wins over start in IDLE
        load_en = 1'b1; start = 1'b1; load_val = 4'h0;
        cyc(4'hA, 1'b1, 1'b0, 1'b0, "load_prio");
        load_en = 1'b0; start = 1'b0;
        cyc(4'h0, 1'b0, 1'b0, 1'b0, "load_prio_done");

        // up modulo 5, parameter changes during RUN are ignored
        start = 1'b1; mode_up = 1'b1; mod_val = 4'h5; one_shot = 1'b0;
        cyc(4'h0, 1'b1, 1'b0, 1'b0, "up_start");
        start = 1'b0; mode_up = 1'b0; mod_val = 4'h2; one_shot = 1'b1;
        cyc(4'h1, 1'b1, 1'b0, 1'b0, "up1");
        load_en = 1'b1; load_val = 4'hE; start = 1'b1;
        cyc(4'h2, 1'b1, 1'b0, 1'b0, "up2_load_ignored");
        load_en = 1'b0; start = 1'b0;
        cyc(4'h3, 1'b1, 1'b0, 1'b0, "up3");
        cyc(4'h4, 1'b1, 1'b0, 1'b0, "up4");
        cyc(4'h5, 1'b1, 1'b0, 1'b0, "up5");
        cyc(4'h0, 1'b1, 1'b1, 1'b0, "up_wrap");
        cyc(4'h1, 1'b1, 1'b0, 1'b0, "up_after_wrap");
        cyc(4'h2, 1'b1, 1'b0, 1'b0, "up_again");
        stop = 1'b1;
        cyc(4'h2, 1'b0, 1'b0, 1'b0, "up_stop");
        stop = 1'b0;

        // down one-shot from 3, modulo 9
        do_load(4'h3, 4'h2);
        start = 1'b1; mode_up = 1'b0; mod_val = 4'h9; one_shot = 1'b1;
        cyc(4'h3, 1'b1, 1'b0, 1'b0, "dn_start");
        start = 1'b0;
        cyc(4'h2, 1'b1, 1'b0, 1'b0, "dn2");
        cyc(4'h1, 1'b1, 1'b0, 1'b0, "dn1");
        cyc(4'h0, 1'b1, 1'b0, 1'b0, "dn0");
        cyc(4'h9, 1'b0, 1'b1, 1'b1, "dn_wrap_done");
        cyc(4'h9, 1'b0, 1'b0, 1'b1, "done_hold1");
        cyc(4'h9, 1'b0, 1'b0, 1'b1, "done_hold2");

        // restart from DONE: up mod 3 starting above mod, natural overflow, stop at terminal
        start = 1'b1; mode_up = 1'b1; mod_val = 4'h3; one_shot = 1'b0;
        cyc(4'h9, 1'b1, 1'b0, 1'b0, "restart");
        start = 1'b0;
        for (int v = 10; v < 16; v++) begin
            cyc(4'(v), 1'b1, 1'b0, 1'b0, "overflow_run");
        end
        cyc(4'h0, 1'b1, 1'b0, 1'b0, "natural_wrap");
        cyc(4'h1, 1'b1, 1'b0, 1'b0, "post_wrap1");
        cyc(4'h2, 1'b1, 1'b0, 1'b0, "post_wrap2");
        cyc(4'h3, 1'b1, 1'b0, 1'b0, "at_terminal");
        stop = 1'b1;
        cyc(4'h3, 1'b0, 1'b0, 1'b0, "stop_at_terminal");
        stop = 1'b0;

        // mod_val == 0 counting up: q sticks at 0, tc every cycle
        do_load(4'h0, 4'h3);
        start = 1'b1; mode_up = 1'b1; mod_val = 4'h0; one_shot = 1'b0;
        cyc(4'h0, 1'b1, 1'b0, 1'b0, "mod0_start");
        start = 1'b0;
        cyc(4'h0, 1'b1, 1'b1, 1'b0, "mod0_a");
        cyc(4'h0, 1'b1, 1'b1, 1'b0, "mod0_b");
        stop = 1'b1;
        cyc(4'h0, 1'b0, 1'b0, 1'b0, "mod0_stop");
        stop = 1'b0;

        // reset mid-run at q=6
        start = 1'b1; mode_up = 1'b1; mod_val = 4'hF;
        cyc(4'h0, 1'b1, 1'b0, 1'b0, "rr_start");
        start = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            cyc(4'(v), 1'b1, 1'b0, 1'b0, "rr_count");
        end
        rst_n = 1'b0; start = 1'b1;
        cyc(4'h0, 1'b0, 1'b0, 1'b0, "rr_reset");
        rst_n = 1'b1; start = 1'b0;
        cyc(4'h0, 1'b0, 1'b0, 1'b0, "rr_idle");

        // reset mid-load: no partial load
        load_en = 1'b1; load_val = 4'hC;
        cyc(4'h0, 1'b1, 1'b0, 1'b0, "rl_load");
        rst_n = 1'b0; load_en = 1'b0;
        cyc(4'h0, 1'b0, 1'b0, 1'b0, "rl_reset");
        rst_n = 1'b1;
        cyc(4'h0, 1'b0, 1'b0, 1'b0, "rl_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
